bnn_sample_sequencer: RTL and testbench

- Upstream controller for the rolled single-hidden-layer BNN classifier (`winewhite_bnn1_bnnroll` family).
- Accepts feature values one at a time over a valid/ready stream and assembles them into a full packed feature vector.
- Starts the classifier with a one-cycle start pulse, waits its fixed compute latency, then returns the prediction on a valid/ready output.
- Double-buffered: the next sample loads while the current one is being classified.

---
 rtl/bnn_sample_sequencer.sv | 178 +++++++++++++++++
 tb/tb_bnn_sample_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_sample_sequencer.sv
// ============================================================================
// Module : bnn_sample_sequencer
// Brief  : Double-buffered feature loader and start/latency sequencer for the
//          rolled single-hidden-layer BNN classifier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bnn_sample_sequencer #(
    parameter int FEAT_CNT   = 11,
    parameter int FEAT_BITS  = 4,
    parameter int HIDDEN_CNT = 40,
    parameter int CLASS_CNT  = 7,
    parameter int RUN_CYCLES = 2*HIDDEN_CNT+1,
    parameter int CNT_BITS   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [FEAT_BITS-1:0]          in_feat,
    output logic [FEAT_BITS*FEAT_CNT-1:0] bnn_features,
    output logic                          bnn_rst,
    input  logic [$clog2(CLASS_CNT)-1:0]  bnn_prediction,
    output logic                          pred_valid,
    input  logic                          pred_ready,
    output logic [$clog2(CLASS_CNT)-1:0]  pred_class,
    output logic                          pred_oob,
    output logic [CNT_BITS-1:0]           sample_cnt
);

    localparam int c_pred_w = $clog2(CLASS_CNT);
    localparam int c_lidx_w = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
    localparam int c_rcnt_w = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam int c_vec_w  = FEAT_BITS*FEAT_CNT;

    localparam logic [c_lidx_w-1:0] c_lidx_last = c_lidx_w'(FEAT_CNT-1);
    localparam logic [c_rcnt_w-1:0] c_run_last  = c_rcnt_w'(RUN_CYCLES-1);
    localparam logic [c_pred_w-1:0] c_class_max = c_pred_w'(CLASS_CNT-1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [c_lidx_w-1:0]   r_lidx;
    logic                  r_lfull;
    logic [c_rcnt_w-1:0]   r_run_cnt;
    logic [c_vec_w-1:0]    r_run_vec;
    logic [c_vec_w-1:0]    w_load_vec;
    logic                  w_load;
    logic                  w_transfer;
    logic                  w_run_last;

    assign in_ready     = !r_lfull;
    assign w_load       = in_valid && !r_lfull;
    assign w_run_last   = (r_state == S_RUN) && (r_run_cnt == c_run_last);
    assign bnn_features = r_run_vec;

    // Load buffer slots, packed so feature k sits at [k*FEAT_BITS +: FEAT_BITS]
    for (genvar k = 0; k < FEAT_CNT; k++) begin : g_slot
        logic [FEAT_BITS-1:0] r_slot;

        always_ff @(posedge clk) begin
            if (!rst) begin
                r_slot <= '0;
            end else if (w_load && (r_lidx == c_lidx_w'(k))) begin
                r_slot <= in_feat;
            end
        end

        assign w_load_vec[k*FEAT_BITS +: FEAT_BITS] = r_slot;
    end

    // A transfer needs lfull and a load cannot, so the two never coincide
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lidx  <= '0;
            r_lfull <= 1'b0;
        end else begin
            if (w_transfer) begin
                r_lfull <= 1'b0;
            end
            if (w_load) begin
                if (r_lidx == c_lidx_last) begin
                    r_lidx  <= '0;
                    r_lfull <= 1'b1;
                end else begin
                    r_lidx <= r_lidx + c_lidx_w'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_transfer   = 1'b0;
        bnn_rst      = 1'b0;
        pred_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_lfull) begin
                    w_transfer   = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                bnn_rst      = 1'b1;
                w_state_next = S_RUN;
            end
            S_RUN: begin
                if (r_run_cnt == c_run_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                pred_valid = 1'b1;
                if (pred_ready) begin
                    if (r_lfull) begin
                        w_transfer   = 1'b1;
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_run_vec <= '0;
            r_run_cnt <= '0;
        end else begin
            if (w_transfer) begin
                r_run_vec <= w_load_vec;
            end
            if (r_state == S_START) begin
                r_run_cnt <= '0;
            end else if (r_state == S_RUN) begin
                r_run_cnt <= r_run_cnt + c_rcnt_w'(1);
            end
        end
    end

    // Prediction captured on the last RUN cycle and held through DONE
    always_ff @(posedge clk) begin
        if (!rst) begin
            pred_class <= '0;
            pred_oob   <= 1'b0;
            sample_cnt <= '0;
        end else begin
            if (w_run_last) begin
                pred_class <= (bnn_prediction > c_class_max) ? c_class_max : bnn_prediction;
                pred_oob   <= (bnn_prediction > c_class_max);
            end
            if ((r_state == S_DONE) && pred_ready) begin
                sample_cnt <= sample_cnt + CNT_BITS'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bnn_sample_sequencer.sv
// ============================================================================
// Module : tb_bnn_sample_sequencer
// Brief  : Directed self-checking bench for bnn_sample_sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bnn_sample_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_feat;
    logic [43:0] bnn_features;
    logic        bnn_rst;
    logic [2:0]  stub_pred;
    logic        pred_valid;
    logic        pred_ready;
    logic [2:0]  pred_class;
    logic        pred_oob;
    logic [15:0] sample_cnt;

    logic        wr_in_valid;
    logic        wr_in_ready;
    logic [3:0]  wr_in_feat;
    logic [7:0]  wr_features;
    logic        wr_bnn_rst;
    logic [2:0]  wr_stub;
    logic        wr_pred_valid;
    logic        wr_pred_ready;
    logic [2:0]  wr_pred_class;
    logic        wr_pred_oob;
    logic [7:0]  wr_sample_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bnn_sample_sequencer u_dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_feat        (in_feat),
        .bnn_features   (bnn_features),
        .bnn_rst        (bnn_rst),
        .bnn_prediction (stub_pred),
        .pred_valid     (pred_valid),
        .pred_ready     (pred_ready),
        .pred_class     (pred_class),
        .pred_oob       (pred_oob),
        .sample_cnt     (sample_cnt)
    );

    bnn_sample_sequencer #(
        .FEAT_CNT   (2),
        .FEAT_BITS  (4),
        .HIDDEN_CNT (0),
        .CLASS_CNT  (7),
        .RUN_CYCLES (1),
        .CNT_BITS   (8)
    ) u_wrap (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (wr_in_valid),
        .in_ready       (wr_in_ready),
        .in_feat        (wr_in_feat),
        .bnn_features   (wr_features),
        .bnn_rst        (wr_bnn_rst),
        .bnn_prediction (wr_stub),
        .pred_valid     (wr_pred_valid),
        .pred_ready     (wr_pred_ready),
        .pred_class     (wr_pred_class),
        .pred_oob       (wr_pred_oob),
        .sample_cnt     (wr_sample_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_feat(input logic [3:0] v);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_feat  = v;
        while (!in_ready && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) chk("send_timeout", in_ready, 1);
        tick();
    endtask

    task automatic send_sample(input logic [43:0] vec);
        for (int k = 0; k < 11; k++) send_feat(vec[k*4 +: 4]);
        in_valid = 1'b0;
    endtask

    task automatic wait_pred(output int n);
        n = 0;
        while (!pred_valid && n < 400) begin
            tick();
            n++;
        end
        chk("pred_valid_wait", pred_valid, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int hi;
        int n;
        int cyc;

        rst           = 1'b0;
        in_valid      = 1'b0;
        in_feat       = '0;
        pred_ready    = 1'b0;
        stub_pred     = '0;
        wr_in_valid   = 1'b0;
        wr_in_feat    = '0;
        wr_pred_ready = 1'b0;
        wr_stub       = 3'd4;
        repeat (3) tick();

        chk("rst_in_ready",   in_ready, 1);
        chk("rst_features",   bnn_features, 0);
        chk("rst_bnn_rst",    bnn_rst, 0);
        chk("rst_pred_valid", pred_valid, 0);
        chk("rst_sample_cnt", sample_cnt, 0);
        rst = 1'b1;

        // Sample 1..11, prediction 3
        stub_pred = 3'd3;
        send_sample(44'hBA987654321);
        chk("full_in_ready", in_ready, 0);
        tick();
        chk("start_pulse",    bnn_rst, 1);
        chk("start_features", bnn_features, 44'hBA987654321);
        chk("start_in_ready", in_ready, 1);
        lat = 0;
        hi  = 0;
        while (!pred_valid && lat < 400) begin
            tick();
            lat++;
            if (bnn_rst) hi++;
        end
        chk("latency",       lat, 82);
        chk("single_pulse",  hi, 0);
        chk("class_3",       pred_class, 3);
        chk("oob_3",         pred_oob, 0);
        chk("cnt_before",    sample_cnt, 0);
        pred_ready = 1'b1;
        tick();
        chk("cnt_after",     sample_cnt, 1);
        chk("idle_pv",       pred_valid, 0);
        chk("idle_bnn_rst",  bnn_rst, 0);
        pred_ready = 1'b0;

        // Sample A with out-of-range prediction; sample B loaded during A's RUN
        stub_pred = 3'd7;
        send_sample(44'h56789ABCDEF);
        tick();
        chk("a_start",    bnn_rst, 1);
        chk("a_features", bnn_features, 44'h56789ABCDEF);
        tick();
        send_sample(44'hA9876543210);
        chk("b_full_in_ready",  in_ready, 0);
        chk("a_features_held",  bnn_features, 44'h56789ABCDEF);
        pred_ready = 1'b1;
        wait_pred(n);
        chk("class_clamp", pred_class, 6);
        chk("oob_flag",    pred_oob, 1);
        tick();
        chk("b_no_idle",   bnn_rst, 1);
        chk("b_features",  bnn_features, 44'hA9876543210);
        chk("b_cnt",       sample_cnt, 2);
        chk("b_pv_low",    pred_valid, 0);

        // Stall DONE of B for 20 cycles while sample C fills the buffer
        pred_ready = 1'b0;
        stub_pred  = 3'd2;
        tick();
        send_sample(44'hEDCBA987654);
        wait_pred(n);
        chk("b_class", pred_class, 2);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("stall_pv",       pred_valid, 1);
            chk("stall_class",    pred_class, 2);
            chk("stall_cnt",      sample_cnt, 2);
            chk("stall_in_ready", in_ready, 0);
        end
        pred_ready = 1'b1;
        tick();
        chk("c_start",    bnn_rst, 1);
        chk("c_cnt",      sample_cnt, 3);
        chk("c_features", bnn_features, 44'hEDCBA987654);
        pred_ready = 1'b0;

        // Reset at RUN count 40 of sample C
        repeat (41) tick();
        rst = 1'b0;
        tick();
        chk("mrst_features", bnn_features, 0);
        chk("mrst_class",    pred_class, 0);
        chk("mrst_oob",      pred_oob, 0);
        chk("mrst_cnt",      sample_cnt, 0);
        chk("mrst_in_ready", in_ready, 1);
        chk("mrst_pv",       pred_valid, 0);
        chk("mrst_bnn_rst",  bnn_rst, 0);
        rst = 1'b1;
        hi  = 0;
        repeat (100) begin
            tick();
            if (pred_valid || bnn_rst) hi++;
        end
        chk("mrst_no_output", hi, 0);

        // Reset after a partial load of 5 features
        for (int k = 0; k < 5; k++) send_feat(4'h9);
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("prst_in_ready", in_ready, 1);
        chk("prst_features", bnn_features, 0);
        stub_pred = 3'd5;
        send_sample(44'hBA987654321);
        tick();
        chk("d_start",    bnn_rst, 1);
        chk("d_features", bnn_features, 44'hBA987654321);

        // Load completion coinciding with the DONE handshake
        for (int k = 0; k < 10; k++) send_feat(4'h7);
        in_valid   = 1'b0;
        pred_ready = 1'b1;
        wait_pred(n);
        chk("d_class", pred_class, 5);
        in_valid = 1'b1;
        in_feat  = 4'h7;
        tick();
        in_valid = 1'b0;
        chk("sim_pv",       pred_valid, 0);
        chk("sim_bnn_rst",  bnn_rst, 0);
        chk("sim_in_ready", in_ready, 0);
        chk("sim_cnt",      sample_cnt, 1);
        tick();
        chk("sim_start",    bnn_rst, 1);
        chk("sim_features", bnn_features, 44'h77777777777);
        pred_ready = 1'b0;

        // Counter wrap on the short-latency instance
        wr_in_valid   = 1'b1;
        wr_in_feat    = 4'h5;
        wr_pred_ready = 1'b1;
        n   = 0;
        cyc = 0;
        while (n < 255 && cyc < 5000) begin
            if (wr_pred_valid) n++;
            tick();
            cyc++;
        end
        chk("wrap_cnt_max",  wr_sample_cnt, 8'hFF);
        chk("wrap_class",    wr_pred_class, 4);
        chk("wrap_features", wr_features, 8'h55);
        cyc = 0;
        while (!wr_pred_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        tick();
        chk("wrap_cnt_zero", wr_sample_cnt, 0);
        wr_in_valid   = 1'b0;
        wr_pred_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
